// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer: issues one ALU operation at a time, waits for the result
// to settle, and returns it over a valid/ready response channel.
// Optional operand chaining with macro ALU_SEQ_CHAIN_EN.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_op_sequencer #(
  parameter int DATA_W        = 8,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
`ifdef ALU_SEQ_CHAIN_EN
  input  logic              req_chain,
`endif
  output logic [3:0]        alu_sel,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_o,
  input  logic [DATA_W-1:0] alu_left,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic [DATA_W-1:0] rsp_left,
  output logic              rsp_err,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0]       LAST_LEGAL  = 4'b1100;
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t              state_q;
  logic [3:0]          settle_q;
  logic                req_ready_q;
  logic                rsp_valid_q;
  logic                rsp_err_q;
  logic                busy_q;
  logic [3:0]          alu_sel_q;
  logic [DATA_W-1:0]   alu_a_q;
  logic [DATA_W-1:0]   alu_b_q;
  logic [DATA_W-1:0]   rsp_result_q;
  logic [DATA_W-1:0]   rsp_left_q;
  logic [CNT_W-1:0]    op_count_q;
  logic                legal_d;
  logic [DATA_W-1:0]   a_src_d;

  assign legal_d = (req_op <= LAST_LEGAL);

`ifdef ALU_SEQ_CHAIN_EN
  logic [DATA_W-1:0] last_q;
  logic              last_valid_q;

  assign a_src_d = (req_chain && last_valid_q) ? last_q : req_a;
`else
  assign a_src_d = req_a;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      settle_q     <= 4'd0;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
      alu_sel_q    <= 4'd0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_result_q <= '0;
      rsp_left_q   <= '0;
      op_count_q   <= '0;
`ifdef ALU_SEQ_CHAIN_EN
      last_q       <= '0;
      last_valid_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (legal_d) begin
              alu_sel_q <= req_op;
              alu_a_q   <= a_src_d;
              alu_b_q   <= req_b;
              settle_q  <= SETTLE_LOAD;
              state_q   <= EXEC;
            end else begin
              // Illegal opcode skips the ALU entirely; the issued bus is untouched.
              rsp_result_q <= '0;
              rsp_left_q   <= '0;
              rsp_err_q    <= 1'b1;
              rsp_valid_q  <= 1'b1;
              state_q      <= RESP;
`ifdef ALU_SEQ_CHAIN_EN
              last_valid_q <= 1'b0;
`endif
            end
          end
        end
        EXEC: begin
          if (settle_q == 4'd0) begin
            rsp_result_q <= alu_o;
            rsp_left_q   <= alu_left;
            rsp_err_q    <= 1'b0;
            rsp_valid_q  <= 1'b1;
            state_q      <= RESP;
`ifdef ALU_SEQ_CHAIN_EN
            last_q       <= alu_o;
            last_valid_q <= 1'b1;
`endif
          end else begin
            settle_q <= settle_q - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
            if (op_count_q != {CNT_W{1'b1}}) begin
              op_count_q <= op_count_q + CNT_ONE;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = busy_q;
  assign alu_sel    = alu_sel_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign rsp_result = rsp_result_q;
  assign rsp_left   = rsp_left_q;
  assign op_count   = op_count_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_op_sequencer: scoreboard bench with a behavioural ALU on the bus.
// Chaining checks are included when ALU_SEQ_CHAIN_EN is defined.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alu_op_sequencer;

  localparam int DW = 8;
  localparam int SC = 2;
  localparam int CW = 4;  // narrow counter so saturation is reachable quickly

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [3:0]    req_op;
  logic [DW-1:0] req_a, req_b;
`ifdef ALU_SEQ_CHAIN_EN
  logic          req_chain;
`endif
  logic [3:0]    alu_sel;
  logic [DW-1:0] alu_a, alu_b, alu_o, alu_left;
  logic          rsp_valid, rsp_ready, rsp_err, busy;
  logic [DW-1:0] rsp_result, rsp_left;
  logic [CW-1:0] op_count;

  always #5 clk = ~clk;

  alu_op_sequencer #(.DATA_W(DW), .SETTLE_CYCLES(SC), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
`ifdef ALU_SEQ_CHAIN_EN
    .req_chain(req_chain),
`endif
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b),
    .alu_o(alu_o), .alu_left(alu_left),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_left(rsp_left), .rsp_err(rsp_err),
    .busy(busy), .op_count(op_count)
  );

  // Behavioural ALU: returns {leftover, result}.
  function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0]  s;
    logic [15:0] p;
    logic [15:0] r;
    s = 9'd0;
    p = 16'd0;
    r = 16'd0;
    case (op)
      4'h0: begin s = {1'b0, a} + {1'b0, b}; r = {7'd0, s[8], s[7:0]}; end
      4'h1: r = {7'd0, (a < b), a - b};
      4'h2: begin p = a * b; r = p; end
      4'h3: r = (b == 8'd0) ? {a, 8'hFF} : {a % b, a / b};
      4'h4: r = {8'd0, a & b};
      4'h5: r = {8'd0, a | b};
      4'h6: r = {8'd0, a ^ b};
      4'h7: r = {8'd0, ~a};
      4'h8: r = {15'd0, (a == b)};
      4'h9: r = {15'd0, (a < b)};
      4'hA: r = {15'd0, (a > b)};
      4'hB: r = {15'd0, (a >= b)};
      4'hC: r = {8'd0, a[6:0], a[7]};
      default: r = 16'd0;
    endcase
    return r;
  endfunction

  always_comb {alu_left, alu_o} = alu_fn(alu_sel, alu_a, alu_b);

  typedef struct {
    logic [7:0] res;
    logic [7:0] left;
    logic       err;
    int         acc;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         n_total = 0;
  int         n_bad = 0;
  bit         vseen = 1'b0;
  logic [7:0] b_last = 8'd0;
  bit         b_lv = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Response monitor: first-valid latency and payload at the handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      vseen = 1'b0;
    end else if (rsp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        if (!vseen) begin
          chk("latency", cyc - sb[0].acc, sb[0].lat);
          vseen = 1'b1;
        end
        if (rsp_ready) begin
          chk("rsp_result", rsp_result, sb[0].res);
          chk("rsp_left", rsp_left, sb[0].left);
          chk("rsp_err", rsp_err, sb[0].err);
          void'(sb.pop_front());
          vseen = 1'b0;
        end
      end
    end
  end

  // Present a request, wait for acceptance, push the expected response.
  // Returns at 1 time unit after the accept edge with req_valid still high.
  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic ch, output int acc);
    exp_t       e;
    logic [7:0] ae;
    logic [15:0] lr;
    bit         ok;
    ok = 1'b0;
    req_op = op;
    req_a = a;
    req_b = b;
    req_valid = 1'b1;
`ifdef ALU_SEQ_CHAIN_EN
    req_chain = ch;
`endif
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      acc = -1;
      return;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    ae = (ch && b_lv) ? b_last : a;
    if (op <= 4'hC) begin
      lr = alu_fn(op, ae, b);
      e.res = lr[7:0];
      e.left = lr[15:8];
      e.err = 1'b0;
      e.lat = SC;
      b_last = lr[7:0];
      b_lv = 1'b1;
    end else begin
      e.res = 8'd0;
      e.left = 8'd0;
      e.err = 1'b1;
      e.lat = 0;
      b_lv = 1'b0;
    end
    e.acc = acc;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    int a0, a1, a2, acc;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_op = 4'd0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
`ifdef ALU_SEQ_CHAIN_EN
    req_chain = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_bus", {alu_sel, alu_a, alu_b}, 0);
    chk("rst_rsp", {rsp_result, rsp_left, rsp_err}, 0);
    chk("rst_count", op_count, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Add with carry out
    rsp_ready = 1'b1;
    send(4'h0, 8'hF0, 8'h20, 1'b0, acc);
    req_valid = 1'b0;
    chk("exec_busy", busy, 1);
    chk("exec_ready", req_ready, 0);
    wait_idle();
    chk("add_count", op_count, 1);

    // Backpressure on the response channel while another request waits
    rsp_ready = 1'b0;
    send(4'h5, 8'h0F, 8'hF0, 1'b0, acc);
    req_valid = 1'b0;
    for (int i = 0; i < 20 && !rsp_valid; i++) @(posedge clk);
    #1;
    chk("bp_valid", rsp_valid, 1);
    req_op = 4'h0;
    req_a = 8'h01;
    req_b = 8'h01;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold", rsp_result, 8'hFF);
      chk("bp_ready", req_ready, 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_handshake", rsp_valid, 0);
    chk("bp_count", op_count, 2);
    chk("bp_ignored", alu_sel, 4'h5);
    wait_idle();

    // Illegal opcode then a legal compare
    send(4'hE, 8'hAA, 8'h55, 1'b0, acc);
    req_valid = 1'b0;
    chk("ill_sel", alu_sel, 4'h5);
    chk("ill_a", alu_a, 8'h0F);
    wait_idle();
    send(4'h8, 8'h33, 8'h33, 1'b0, acc);
    req_valid = 1'b0;
    wait_idle();
    chk("ill_count", op_count, 4);

    // Reset one cycle after accepting an operation
    send(4'h2, 8'h03, 8'h04, 1'b0, acc);
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", req_ready, 1);
    chk("mid_rst_sel", alu_sel, 0);
    chk("mid_rst_count", op_count, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    b_lv = 1'b0;
    b_last = 8'd0;
    repeat (8) @(posedge clk);
    #1;
    chk("post_rst_valid", rsp_valid, 0);
    chk("post_rst_count", op_count, 0);

    // Back-to-back with the consumer always ready
    send(4'h0, 8'h01, 8'h02, 1'b0, a0);
    send(4'h1, 8'h09, 8'h03, 1'b0, a1);
    send(4'h3, 8'h64, 8'h07, 1'b0, a2);
    req_valid = 1'b0;
    chk("b2b_space1", a1 - a0, SC + 2);
    chk("b2b_space2", a2 - a1, SC + 2);
    wait_idle();
    chk("b2b_count", op_count, 3);

    for (int i = 0; i < 12; i++) begin
      send(4'($urandom_range(0, 12)), 8'($urandom), 8'($urandom), 1'b0, acc);
    end
    req_valid = 1'b0;
    wait_idle();
    chk("count_max", op_count, 15);
    send(4'h6, 8'hA5, 8'h3C, 1'b0, acc);
    req_valid = 1'b0;
    wait_idle();
    chk("count_sat", op_count, 15);

`ifdef ALU_SEQ_CHAIN_EN
    send(4'h0, 8'h05, 8'h03, 1'b0, acc);
    req_valid = 1'b0;
    wait_idle();
    send(4'h2, 8'h77, 8'h02, 1'b1, acc);
    req_valid = 1'b0;
    req_chain = 1'b0;
    chk("chain_a", alu_a, 8'h08);
    wait_idle();
    chk("chain_result", rsp_result, 8'h10);
`endif

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Sequences one 8-bit ALU operation at a time through the shared ALU result multiplexer. The multiplexer covers arithmetic codes 0000-0011, logic codes 0100-0111, compare codes 1000-1011 and knight-rider code 1100.
- Accepts an opcode plus two operands over a valid/ready request channel.
- Drives the ALU select and operand buses and waits a fixed settle time.
- Captures the result and leftover (carry/borrow/remainder) and returns them over a valid/ready response channel.
- Sits between the front-end command source and the ALU datapath.

Parameters:
- DATA_W, 8, width of operands, result and leftover.
- SETTLE_CYCLES, 2, cycles the select/operands are held before the result is sampled (legal range 1..15).
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous reset, active low.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_op  in  4  opcode, same encoding as the ALU select.
- req_a  in  DATA_W  operand A.
- req_b  in  DATA_W  operand B.
- alu_sel  out  4  select to the ALU result mux (registered).
- alu_a  out  DATA_W  operand A to the ALU (registered).
- alu_b  out  DATA_W  operand B to the ALU (registered).
- alu_o  in  DATA_W  ALU result.
- alu_left  in  DATA_W  ALU leftover.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  DATA_W  captured result.
- rsp_left  out  DATA_W  captured leftover.
- rsp_err  out  1  opcode was illegal (1101-1111).
- busy  out  1  high whenever state is not IDLE.
- op_count  out  CNT_W  completed responses, saturating.

Behaviour:
- Reset values (async on rst_n low): state IDLE, req_ready 1, rsp_valid 0, rsp_err 0, busy 0, alu_sel 0000, alu_a 0, alu_b 0, rsp_result 0, rsp_left 0, op_count 0, settle counter 0.
- Reset mid-operation aborts the operation; no response is produced.
- States: IDLE, EXEC, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready at edge T with a legal opcode (0000-1100): register alu_sel/alu_a/alu_b from the request, load the settle counter with SETTLE_CYCLES-1, go to EXEC.
  - On an illegal opcode (1101-1111): go directly to RESP with rsp_err = 1, rsp_result = 0 and rsp_left = 0. alu_sel/alu_a/alu_b are unchanged. rsp_valid is high in cycle T+1.
- EXEC:
  - req_ready = 0.
  - The counter decrements each cycle.
  - In the cycle the counter is 0: sample alu_o into rsp_result and alu_left into rsp_left, set rsp_err = 0, go to RESP.
  - Legal-op latency: rsp_valid is first high SETTLE_CYCLES+1 cycles after the accept edge. Example: SETTLE_CYCLES = 2, accept at edge T, rsp_valid high from cycle T+3.
- RESP:
  - rsp_valid = 1; rsp_result, rsp_left and rsp_err are held stable until rsp_valid & rsp_ready.
  - On that handshake: op_count increments, saturating at 2^CNT_W-1, and state returns to IDLE.
  - No request is accepted in the handshake cycle; the earliest next accept is the following cycle.
- alu_sel/alu_a/alu_b hold their last issued values in IDLE and RESP.
- rsp_result/rsp_left hold their last values after the handshake.
- Leftover is passed through as-is for every opcode. The ALU is responsible for zeroing it on codes 0100-1100.
- Requests presented while req_ready = 0 are ignored; the requester holds them.
- Counter wrap: op_count saturates and never wraps.

Optional Feature:
- Macro ALU_SEQ_CHAIN_EN.
- Defined:
  - Adds input port req_chain (1 bit) and an internal last-result register, reset 0, with a last_valid flag, reset 0.
  - When a legal request is accepted with req_chain = 1 and last_valid = 1, alu_a is loaded from the last-result register instead of req_a.
  - Every legal completion updates the last-result register and sets last_valid.
  - An illegal opcode clears last_valid.
- Not defined: req_chain port and the register are absent; alu_a always comes from req_a.

Test Plan:
- Add: op 0000, A = 8'hF0, B = 8'h20, ALU model returns O = 8'h10, left = 1 -> rsp_valid at T+3 with rsp_result 8'h10, rsp_left 8'h01, rsp_err 0, op_count 1.
- Backpressure: op 0101, A = 8'h0F, B = 8'hF0, rsp_ready held 0 for 5 cycles -> rsp_result stays 8'hFF, req_ready stays 0, new req_valid is ignored, the handshake occurs on the cycle rsp_ready = 1.
- Illegal op 1110 -> rsp_valid at T+1, rsp_err 1, result 0, alu_sel still shows the previous op; the next legal op 1000 completes normally.
- Reset mid-EXEC: assert rst_n = 0 one cycle after accepting op 0010 -> all outputs at reset values immediately, no rsp_valid after release, op_count 0.
- Back-to-back: 3 requests with rsp_ready tied 1 -> accepts spaced SETTLE_CYCLES+2 cycles apart, op_count 3; force op_count to 16'hFFFF, complete one more op -> stays 16'hFFFF.
- ALU_SEQ_CHAIN_EN: op 0000 with 5 + 3 = 8, then op 0010 with req_chain = 1 and req_a = 8'h77 -> alu_a = 8'h08, result 8'h10.
